inst_seq: RTL and testbench
===========================

Name: inst_seq

Overview:
Instruction fetch/decode sequencer that drives the ALU's operand and opcode inputs (Lbus, Rbus, OP) and consumes its registered result (Obus).
- Fetches 16-bit instruction words over a req/ack handshake.
- Owns a 4x16 register file, sources operands from it, and writes ALU results back.
- Sits between instruction memory and the ALU as the CPU control path.

Parameters:
PC_W, 8, width of program counter / instruction address; wraps modulo 2^PC_W.

Ports:
clk  in  1  system clock, all state on rising edge
res  in  1  reset, asynchronous, active-low (0 = reset)
ins_req  out  1  instruction fetch request
ins_addr  out  PC_W  fetch address (= PC)
ins_ack  in  1  memory ack; ins_data valid in the same cycle
ins_data  in  16  instruction word
OP  out  4  ALU opcode, OP_* encodings from define.v
Lbus  out  16  ALU left operand
Rbus  out  16  ALU right operand
Obus  in  16  ALU result; ALU registers it one clk after OP
halt  out  1  high once HALT has executed
dbg_sel  in  2  register-file debug read select
dbg_data  out  16  combinational read of reg[dbg_sel]

Behaviour:
- Instruction format: [15:12] opc, [11:10] rd, [9:8] rs, [7:0] imm8.
- Reset (res=0, async): PC=0, all regs=0, OP=OP_NOP, Lbus=Rbus=0, ins_req=0, halt=0, state=FETCH. All outputs are registered except dbg_data.
- Reset mid-operation: aborts the current instruction; no writeback. An ins_ack in flight is ignored.
- FETCH:
  - ins_req=1, ins_addr=PC, both held stable until ins_ack=1 is sampled.
  - On that edge: IR<=ins_data, ins_req<=0, go to DECODE.
  - ins_ack while ins_req=0 is ignored.
- DECODE, by opc:
  - ADD/SUB/AND/OR/XOR: OP<=opc, Lbus<=reg[rd], Rbus<=reg[rs]; go to EXEC.
  - LOADI: OP<=OP_LOADI, Lbus<=0, Rbus<={8'h00,imm8}; go to EXEC.
  - OP_NOP or any unlisted opc except 4'hF: PC<=PC+1, go to FETCH; no regfile change.
  - 4'hF (HALT): halt<=1, go to HALT; PC unchanged.
- EXEC: OP valid for exactly this one cycle; the ALU captures at its end. On exit OP<=OP_NOP, so the ALU holds Obus. Go to WB.
- WB: on exit reg[rd]<=Obus, PC<=PC+1, go to FETCH.
- HALT: terminal state. ins_req=0, OP=OP_NOP, ignores ins_ack; only reset leaves it.
- Latency with zero-wait ack (ack in first FETCH cycle):
  - ALU-class instruction: 4 cycles, FETCH -> DECODE -> EXEC -> WB.
  - NOP/unknown: 2 cycles.
- PC arithmetic is modulo 2^PC_W: PC=2^PC_W-1 increments to 0.
- rd==rs is legal; operands are read in DECODE, before writeback.
- Arithmetic widths are 16-bit; carries are discarded by the ALU.

Optional Feature:
SEXT_IMM_EN
- Defined: LOADI drives Rbus<={{8{imm8[7]}},imm8} (sign-extended).
- Undefined: zero-extended, as above.
- Nothing else changes.

Test Plan:
- Reset: hold res=0 5 cycles -> OP=OP_NOP, Lbus=Rbus=0, ins_req=0, halt=0. Release -> next cycle ins_req=1, ins_addr=0.
- LOADI r1,0x34 (ins_data={OP_LOADI,2'd1,2'd0,8'h34}), ack immediately:
  - EXEC cycle: OP=OP_LOADI, Rbus=16'h0034.
  - After WB: dbg_sel=1 gives dbg_data=16'h0034, ins_addr=1.
  - Total 4 cycles.
- Setup: r1=0x0034, r2=0x000C.
  - ADD r1,r2 -> Lbus=0x0034, Rbus=0x000C, r1=0x0040.
  - Then SUB r2,r1 -> r2=16'hFFCC.
- Wait states: delay ins_ack 3 cycles -> ins_req=1 and ins_addr unchanged throughout; no state advance; regs unchanged.
- Unknown opc 4'h9 at PC=2^PC_W-1 -> no register change, next ins_addr=0. Next word HALT -> halt=1, ins_req stays 0, subsequent ins_ack ignored.
- Reset mid-EXEC of ADD r0,r1 -> r0 stays 0, PC=0, OP=OP_NOP immediately (async).

Source files
------------

// File: rtl/inst_seq.sv
// inst_seq: instruction fetch/decode sequencer driving ALU operands/opcode, 4x16 regfile with writeback.
// Latency: ALU/LOADI op 4 cycles FETCH->DECODE->EXEC->WB; NOP/unknown 2 cycles; HALT is terminal.
// Backpressure: holds ins_req/ins_addr until ins_ack. Define SEXT_IMM_EN to sign-extend the LOADI immediate.
module inst_seq #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            res,
   output logic            ins_req,
   output logic [PC_W-1:0] ins_addr,
   input  logic            ins_ack,
   input  logic [15:0]     ins_data,
   output logic [3:0]      OP,
   output logic [15:0]     Lbus,
   output logic [15:0]     Rbus,
   input  logic [15:0]     Obus,
   output logic            halt,
   input  logic [1:0]      dbg_sel,
   output logic [15:0]     dbg_data
);

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_XOR   = 4'h5;
   localparam logic [3:0] OP_LOADI = 4'h6;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [3:0][15:0]  regs_q, regs_d;
   logic [3:0]        op_q, op_d;
   logic [15:0]       lbus_q, lbus_d;
   logic [15:0]       rbus_q, rbus_d;
   logic              req_q, req_d;
   logic              halt_q, halt_d;

   logic [3:0]  opc;
   logic [1:0]  rd;
   logic [1:0]  rs;
   logic [7:0]  imm8;
   logic [15:0] imm_ext;

   assign opc  = ir_q[15:12];
   assign rd   = ir_q[11:10];
   assign rs   = ir_q[9:8];
   assign imm8 = ir_q[7:0];

`ifdef SEXT_IMM_EN
   assign imm_ext = {{8{imm8[7]}}, imm8};
`else
   assign imm_ext = {8'h00, imm8};
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      regs_d  = regs_q;
      op_d    = op_q;
      lbus_d  = lbus_q;
      rbus_d  = rbus_q;
      req_d   = req_q;
      halt_d  = halt_q;
      case (state_q)
         ST_FETCH: begin
            // First FETCH cycle after reset only raises the request; an ack then is ignored.
            if (!req_q) begin
               req_d = 1'b1;
            end else if (ins_ack) begin
               ir_d    = ins_data;
               req_d   = 1'b0;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (opc)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  op_d    = opc;
                  lbus_d  = regs_q[rd];
                  rbus_d  = regs_q[rs];
                  state_d = ST_EXEC;
               end
               OP_LOADI: begin
                  op_d    = OP_LOADI;
                  lbus_d  = 16'h0000;
                  rbus_d  = imm_ext;
                  state_d = ST_EXEC;
               end
               OP_HALT: begin
                  halt_d  = 1'b1;
                  state_d = ST_HALT;
               end
               default: begin
                  pc_d    = pc_q + PC_W'(1);
                  req_d   = 1'b1;
                  state_d = ST_FETCH;
               end
            endcase
         end
         ST_EXEC: begin
            op_d    = OP_NOP;
            state_d = ST_WB;
         end
         ST_WB: begin
            regs_d[rd] = Obus;
            pc_d       = pc_q + PC_W'(1);
            req_d      = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_HALT: begin
            req_d = 1'b0;
            op_d  = OP_NOP;
         end
         default: begin
            req_d   = 1'b0;
            op_d    = OP_NOP;
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         regs_q  <= '0;
         op_q    <= OP_NOP;
         lbus_q  <= '0;
         rbus_q  <= '0;
         req_q   <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         regs_q  <= regs_d;
         op_q    <= op_d;
         lbus_q  <= lbus_d;
         rbus_q  <= rbus_d;
         req_q   <= req_d;
         halt_q  <= halt_d;
      end
   end

   assign ins_req  = req_q;
   assign ins_addr = pc_q;
   assign OP       = op_q;
   assign Lbus     = lbus_q;
   assign Rbus     = rbus_q;
   assign halt     = halt_q;
   assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_inst_seq.sv
// Bench for inst_seq: directed program, ALU model, queue-based scoreboard for EXEC operands and fetch addresses.
module tb_inst_seq;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        ins_req;
   logic [7:0]  ins_addr;
   logic        ins_ack = 1'b0;
   logic [15:0] ins_data = 16'hDEAD;
   logic [3:0]  OP;
   logic [15:0] Lbus;
   logic [15:0] Rbus;
   logic [15:0] Obus = 16'h0000;
   logic        halt;
   logic [1:0]  dbg_sel = 2'd0;
   logic [15:0] dbg_data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] l;
      logic [15:0] r;
   } exec_t;

   exec_t      exp_exec[$];
   logic [7:0] exp_fetch[$];
   exec_t      mon_e;
   logic [7:0] mon_a;

   inst_seq #(.PC_W(8)) dut (
      .clk(clk), .res(res), .ins_req(ins_req), .ins_addr(ins_addr),
      .ins_ack(ins_ack), .ins_data(ins_data), .OP(OP), .Lbus(Lbus),
      .Rbus(Rbus), .Obus(Obus), .halt(halt), .dbg_sel(dbg_sel),
      .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // ALU model: registers its result one clock after a non-NOP opcode, holds otherwise.
   always @(posedge clk) begin
      case (OP)
         4'h1: Obus <= Lbus + Rbus;
         4'h2: Obus <= Lbus - Rbus;
         4'h3: Obus <= Lbus & Rbus;
         4'h4: Obus <= Lbus | Rbus;
         4'h5: Obus <= Lbus ^ Rbus;
         4'h6: Obus <= Rbus;
         default: Obus <= Obus;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (res) begin
         if (OP != 4'h0) begin
            if (exp_exec.size() == 0) begin
               chk("exec_unexpected_op", {28'h0, OP}, 32'h0);
            end else begin
               mon_e = exp_exec.pop_front();
               chk("exec_op",   {28'h0, OP},   {28'h0, mon_e.op});
               chk("exec_lbus", {16'h0, Lbus}, {16'h0, mon_e.l});
               chk("exec_rbus", {16'h0, Rbus}, {16'h0, mon_e.r});
            end
         end
         if (ins_req && ins_ack) begin
            if (exp_fetch.size() == 0) begin
               chk("fetch_unexpected_addr", {24'h0, ins_addr}, 32'hFFFF_FFFF);
            end else begin
               mon_a = exp_fetch.pop_front();
               chk("fetch_addr", {24'h0, ins_addr}, {24'h0, mon_a});
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reg(input logic [1:0] idx, input logic [15:0] exp);
      dbg_sel = idx;
      #1;
      chk($sformatf("reg%0d", idx), {16'h0, dbg_data}, {16'h0, exp});
   endtask

   // Returns one cycle after the ack edge (DUT in DECODE).
   task automatic fetch(input logic [15:0] word, input int waits, input logic [7:0] addr);
      int n = 0;
      while (ins_req !== 1'b1 && n < 20) begin
         step(1);
         n++;
      end
      if (n >= 20) begin
         chk("fetch_timeout_req", {31'h0, ins_req}, 32'h1);
         return;
      end
      repeat (waits) begin
         step(1);
         chk("wait_req",  {31'h0, ins_req}, 32'h1);
         chk("wait_addr", {24'h0, ins_addr}, {24'h0, addr});
         chk("wait_op",   {28'h0, OP}, 32'h0);
      end
      exp_fetch.push_back(addr);
      ins_data = word;
      ins_ack  = 1'b1;
      step(1);
      ins_ack  = 1'b0;
      ins_data = 16'hDEAD;
   endtask

   task automatic alu_instr(input logic [15:0] word, input int waits, input logic [7:0] addr,
                            input logic [3:0] op, input logic [15:0] l, input logic [15:0] r);
      exec_t e;
      e.op = op;
      e.l  = l;
      e.r  = r;
      exp_exec.push_back(e);
      fetch(word, waits, addr);
   endtask

   // Finishes an ALU instruction: checks WB timing and the next fetch address.
   task automatic finish_alu(input logic [7:0] next_addr);
      step(2);
      chk("wb_req_low",  {31'h0, ins_req}, 32'h0);
      step(1);
      chk("next_req",    {31'h0, ins_req}, 32'h1);
      chk("next_addr",   {24'h0, ins_addr}, {24'h0, next_addr});
   endtask

   logic [15:0] loadi_r3_exp;

   initial begin
`ifdef SEXT_IMM_EN
      loadi_r3_exp = 16'hFF80;
`else
      loadi_r3_exp = 16'h0080;
`endif
      // Reset held for 5 cycles.
      res = 1'b0;
      step(5);
      chk("rst_op",   {28'h0, OP},   32'h0);
      chk("rst_lbus", {16'h0, Lbus}, 32'h0);
      chk("rst_rbus", {16'h0, Rbus}, 32'h0);
      chk("rst_req",  {31'h0, ins_req}, 32'h0);
      chk("rst_halt", {31'h0, halt}, 32'h0);
      res = 1'b1;
      chk("rel_req_still_low", {31'h0, ins_req}, 32'h0);
      step(1);
      chk("rel_req",  {31'h0, ins_req}, 32'h1);
      chk("rel_addr", {24'h0, ins_addr}, 32'h0);

      // LOADI r1,0x34 with zero-wait ack: 4-cycle instruction.
      alu_instr(16'h6434, 0, 8'd0, 4'h6, 16'h0000, 16'h0034);
      finish_alu(8'd1);
      chk_reg(2'd1, 16'h0034);

      alu_instr(16'h680C, 0, 8'd1, 4'h6, 16'h0000, 16'h000C);
      finish_alu(8'd2);
      chk_reg(2'd2, 16'h000C);

      // ADD r1,r2 then SUB r2,r1 with 3 wait states.
      alu_instr(16'h1600, 0, 8'd2, 4'h1, 16'h0034, 16'h000C);
      finish_alu(8'd3);
      chk_reg(2'd1, 16'h0040);
      alu_instr(16'h2900, 3, 8'd3, 4'h2, 16'h000C, 16'h0040);
      finish_alu(8'd4);
      chk_reg(2'd2, 16'hFFCC);
      chk_reg(2'd1, 16'h0040);

      alu_instr(16'h6C80, 0, 8'd4, 4'h6, 16'h0000, loadi_r3_exp);
      finish_alu(8'd5);
      chk_reg(2'd3, loadi_r3_exp);
      // rd == rs: operands read in DECODE.
      alu_instr(16'h5F00, 0, 8'd5, 4'h5, loadi_r3_exp, loadi_r3_exp);
      finish_alu(8'd6);
      chk_reg(2'd3, 16'h0000);

      alu_instr(16'h4100, 0, 8'd6, 4'h4, 16'h0000, 16'h0040);
      finish_alu(8'd7);
      chk_reg(2'd0, 16'h0040);
      alu_instr(16'h3200, 0, 8'd7, 4'h3, 16'h0040, 16'hFFCC);
      finish_alu(8'd8);
      chk_reg(2'd0, 16'h0040);

      // NOP / unknown opcodes up to PC=254: 2-cycle, no writeback.
      for (int pc = 8; pc < 255; pc++) begin
         logic [7:0]  a;
         logic [15:0] w;
         a = 8'(pc);
         if (pc % 2 == 0) w = 16'h0FFF ^ {8'h00, a};
         else             w = {4'(7 + (pc % 8)), 12'hABC};
         fetch(w, 0, a);
      end

      // Unknown opcode at PC=255 wraps the PC to 0.
      fetch(16'h9ABC, 0, 8'd255);
      step(1);
      chk("wrap_req",  {31'h0, ins_req}, 32'h1);
      chk("wrap_addr", {24'h0, ins_addr}, 32'h0);
      chk_reg(2'd0, 16'h0040);
      chk_reg(2'd1, 16'h0040);
      chk_reg(2'd2, 16'hFFCC);
      chk_reg(2'd3, 16'h0000);

      // HALT: terminal, ignores further acks.
      fetch(16'hF000, 0, 8'd0);
      step(1);
      chk("halt_flag", {31'h0, halt}, 32'h1);
      chk("halt_req",  {31'h0, ins_req}, 32'h0);
      ins_data = 16'h6405;
      ins_ack  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("halt_req_acked", {31'h0, ins_req}, 32'h0);
         chk("halt_held",      {31'h0, halt}, 32'h1);
         chk("halt_op",        {28'h0, OP}, 32'h0);
         chk("halt_addr",      {24'h0, ins_addr}, 32'h0);
      end
      ins_ack = 1'b0;
      chk_reg(2'd1, 16'h0040);

      // Reset leaves HALT; then reset mid-EXEC of ADD r0,r1.
      res = 1'b0;
      step(2);
      res = 1'b1;
      chk("rst2_halt", {31'h0, halt}, 32'h0);
      alu_instr(16'h6405, 0, 8'd0, 4'h6, 16'h0000, 16'h0005);
      finish_alu(8'd1);
      chk_reg(2'd1, 16'h0005);
      alu_instr(16'h1100, 0, 8'd1, 4'h1, 16'h0000, 16'h0005);
      @(posedge clk);
      @(negedge clk);
      #1 res = 1'b0;
      #1;
      chk("midrst_op",   {28'h0, OP}, 32'h0);
      chk("midrst_addr", {24'h0, ins_addr}, 32'h0);
      chk("midrst_req",  {31'h0, ins_req}, 32'h0);
      step(3);
      res = 1'b1;
      chk_reg(2'd0, 16'h0000);
      step(4);
      chk("post_rst_op",  {28'h0, OP}, 32'h0);
      chk("post_rst_req", {31'h0, ins_req}, 32'h1);
      chk("post_rst_addr", {24'h0, ins_addr}, 32'h0);
      chk_reg(2'd0, 16'h0000);

      chk("exec_queue_empty",  exp_exec.size(), 32'h0);
      chk("fetch_queue_empty", exp_fetch.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
